jk_updown_counter: RTL and testbench
====================================

// Module: jk_updown_counter
// PURPOSE
//   Synchronous modulo-MODULUS up/down counter built from JK flip-flop cells.
//   Each bit is a JK cell: q_next = (J & ~q) | (~K & q). Per-bit J/K vectors
//   come from explicit excitation logic, not from adding to q.
//   Consumer stage for JK-cell outputs; drives digit/timebase logic downstream.
// PARAMETERS
//   WIDTH    4    counter width in bits; requires MODULUS <= 2**WIDTH
//   MODULUS  10   count range 0..MODULUS-1; must be >= 2
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   en     in   1      count enable
//   up     in   1      1 = count up, 0 = count down; sampled when en=1
//   load   in   1      synchronous parallel load; priority over en
//   din    in   WIDTH  load value
//   q      out  WIDTH  current count (JK cell outputs)
//   tc     out  1      combinational terminal count: en & (up ? q==MODULUS-1 : q==0)
//   wrap   out  1      registered 1-cycle pulse, high the cycle after a wrap
// BEHAVIOUR
//   - Reset: while rst=1, asynchronously q=0, wrap=0. tc follows its equation.
//   - rst asserted mid-count clears immediately. The first count after
//     deassertion happens on the first rising edge with rst=0.
//   - Per-edge priority: load > en > hold.
//   - Load: J=din, K=~din; q=din on the next edge.
//     din >= MODULUS is clamped, so q=MODULUS-1. wrap=0.
//   - Hold (en=0, load=0): J=K=0 for all bits. q and wrap=0 stay put.
//   - Up, q<MODULUS-1: toggle form J[i]=K[i]=&q[i-1:0] (bit 0 always toggles).
//   - Up, q==MODULUS-1: J=0, K=1 for all bits, so q becomes 0. wrap=1 next cycle.
//   - Down, q>0: J[i]=K[i]=~|q[i-1:0] (bit 0 always toggles).
//   - Down, q==0: J=K=0 for cells clear in MODULUS-1; J=1, K=0 for cells set
//     in MODULUS-1. q becomes MODULUS-1. wrap=1 next cycle.
//   - Latency: q updates 1 edge after the control is sampled. wrap lags q by 0
//     cycles: it is registered on the same edge that wraps q.
//   - Changing direction at any count takes effect on the next edge; no lost count.
//   - load and en both high: load wins. No wrap pulse even at terminal.
//   - q is never outside 0..MODULUS-1 after reset or any operation.
// CONFIGURATION
//   JK_CNT_SATURATE_EN
//     defined:   at terminal, J=K=0 (hold). q sticks at MODULUS-1 (up) or 0
//                (down), and wrap is driven constant 0. tc still asserts.
//     undefined: wrap-around as described above (default).
// TESTING
//   1. rst=1 while q=7, no clock edge -> q=0 immediately; wrap=0.
//   2. en=1, up=1, 12 edges from 0 -> q=1..9,0,1,2. tc=1 only at q=9.
//      wrap=1 for exactly one cycle at q=0.
//   3. en=1, up=0 from q=0 -> q=9,8,7. wrap pulse after the 0->9 edge.
//   4. load=1, en=1, din=4'd13 -> q=9 (clamped); wrap=0.
//      Then load=1, din=3 -> q=3.
//   5. Count up to 5, then en=0 for 4 edges -> q holds 5.
//      Flip up=0 with en=1 -> q=4,3.
//   6. With JK_CNT_SATURATE_EN: up from 8, 3 edges -> q=9,9,9; wrap stays 0;
//      tc=1 at 9.

Source files
------------

// File: rtl/jk_updown_counter_if.sv
// Control and status bundle for jk_updown_counter.
// Latency: none. This file holds wiring only.
// Backpressure: none. The counter accepts a control word on every edge.
//
// Ports / signals:
//   en    count enable          (master -> slave)
//   up    direction, 1 = up     (master -> slave)
//   load  synchronous load      (master -> slave)
//   din   load value            (master -> slave)
//   q     current count         (slave -> master)
//   tc    terminal count, comb  (slave -> master)
//   wrap  registered wrap pulse (slave -> master)
interface jk_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, din,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up, load, din,
    output q, tc, wrap
  );
endinterface

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state bits are JK cells driven by excitation logic.
// Latency: q and wrap update 1 edge after control is sampled; tc is combinational.
// Backpressure: none. The counter accepts a control word on every edge.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (q=0, wrap=0)
//   bus (slave)  en/up/load/din in; q/tc/wrap out (see jk_updown_counter_if)
// Configuration macro: JK_CNT_SATURATE_EN
//   When defined, the counter holds at the terminal value instead of wrapping,
//   and wrap stays 0.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  jk_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] load_val;
  logic             at_top, at_zero;

  // Bit i toggles when every lower bit of v is 1. Bit 0 always toggles.
  // Counting up feeds q. Counting down feeds ~q, so that a toggle happens
  // when every lower bit is 0.
  function automatic logic [WIDTH-1:0] carry_chain(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = acc;
      acc  = acc & v[i];
    end
    return t;
  endfunction

  assign at_top  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  // Out-of-range load values clamp to the top of the count range.
  assign load_val = ({1'b0, bus.din} >= MOD_EXT) ? MAX_VAL : bus.din;

  // Excitation logic. The priority is load, then enable, then hold.
  always_comb begin
    j      = '0;
    k      = '0;
    wrap_d = 1'b0;
    if (bus.load) begin
      j = load_val;
      k = ~load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_top) begin
`ifdef JK_CNT_SATURATE_EN
          j = '0;
          k = '0;
`else
          // Clear every cell: MAX -> 0.
          j      = '0;
          k      = '1;
          wrap_d = 1'b1;
`endif
        end else begin
          j = carry_chain(q_q);
          k = carry_chain(q_q);
        end
      end else begin
        if (at_zero) begin
`ifdef JK_CNT_SATURATE_EN
          j = '0;
          k = '0;
`else
          // All cells are 0 here. Setting only the cells that are 1 in MAX gives 0 -> MAX.
          j      = MAX_VAL;
          k      = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          j = carry_chain(~q_q);
          k = carry_chain(~q_q);
        end
      end
    end
    // JK cell characteristic equation, per bit.
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.en & (bus.up ? at_top : at_zero);

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter (WIDTH=4, MODULUS=10).
// The directed steps are followed by random control words, which are checked against an arithmetic model.
module tb_jk_updown_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_q    = 0;
  int m_wrap = 0;
  int wrap_seen;

  jk_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count behaviour computed with modular arithmetic.
  task automatic model_edge(input logic ld, input logic e, input logic u, input int d);
    if (ld) begin
      m_q    = (d >= MOD) ? MOD - 1 : d;
      m_wrap = 0;
    end else if (e) begin
      m_wrap = 0;
      if (u) begin
        if (m_q == MOD - 1) begin
`ifndef JK_CNT_SATURATE_EN
          m_q    = 0;
          m_wrap = 1;
`endif
        end else begin
          m_q = m_q + 1;
        end
      end else begin
        if (m_q == 0) begin
`ifndef JK_CNT_SATURATE_EN
          m_q    = MOD - 1;
          m_wrap = 1;
`endif
        end else begin
          m_q = m_q - 1;
        end
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // This task is entered away from the clock edge. It drives one control word,
  // checks tc before the edge, then checks q, wrap and the range 1 time unit after the edge.
  task automatic step(input logic ld, input logic e, input logic u, input logic [WIDTH-1:0] d);
    logic exp_tc;
    bus.load = ld;
    bus.en   = e;
    bus.up   = u;
    bus.din  = d;
    #1;
    exp_tc = e && (u ? (m_q == MOD - 1) : (m_q == 0));
    check("tc", bus.tc, exp_tc);
    @(posedge clk);
    model_edge(ld, e, u, int'(d));
    #1;
    check("q", bus.q, m_q);
    check("wrap", bus.wrap, m_wrap);
    check("range", (bus.q < MOD), 1);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    m_q    = 0;
    m_wrap = 0;
    check("rst_q", bus.q, 0);
    check("rst_wrap", bus.wrap, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    bus.up   = 1'b1;
    bus.din  = '0;
    #2;
    check("reset_q", bus.q, 0);
    check("reset_wrap", bus.wrap, 0);
    check("reset_tc", bus.tc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Async clear mid-count, with no clock edge involved.
    step(1'b1, 1'b0, 1'b1, 4'd7);
    check("pre_rst_q7", bus.q, 7);
    async_reset();

    // Count up through the wrap.
    wrap_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0);
      if (bus.wrap === 1'b1) wrap_seen++;
    end
`ifndef JK_CNT_SATURATE_EN
    check("up12_q", bus.q, 2);
    check("up12_wraps", wrap_seen, 1);
`endif

    // Count down from 0.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
`ifndef JK_CNT_SATURATE_EN
    check("down3_q", bus.q, 7);
`endif

    // Load clamps and overrides enable.
    step(1'b1, 1'b1, 1'b1, 4'd13);
    check("clamp_q", bus.q, 9);
    check("clamp_wrap", bus.wrap, 0);
    step(1'b1, 1'b0, 1'b1, 4'd3);
    check("load3_q", bus.q, 3);
    // Load at terminal with enable set: there is no wrap pulse.
    step(1'b1, 1'b0, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    check("load_term_wrap", bus.wrap, 0);

    // Count to 5, hold, then reverse direction.
    step(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd0);
    check("hold_q", bus.q, 5);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    check("reverse_q", bus.q, 3);

`ifdef JK_CNT_SATURATE_EN
    step(1'b1, 1'b0, 1'b1, 4'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'd0);
    check("sat_q", bus.q, 9);
    check("sat_wrap", bus.wrap, 0);
`endif

    // Random control words, with an occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
